// File: rtl/multicycle_main_controller_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes,
// ALUOp codes (also consumed by the ALU decoder), datapath select codes,
// FSM state encodings and the control-word bundle.
package multicycle_main_controller_pkg;

    // Opcode field values recognised by the main decoder
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM states; the encoding is visible on state_dbg
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXECUTE = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12
    } state_t;

    // Moore part of the control word decoded from the current state
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    // States that complete an instruction and hand back to FETCH
    function automatic logic is_terminal(input state_t s);
        return s inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP};
    endfunction

    // States that wait on the memory ready handshake
    function automatic logic is_mem_wait(input state_t s);
        return s inside {FETCH, MEMRD, MEMWR};
    endfunction

endpackage

// File: rtl/multicycle_main_controller_perf_counters.sv
// Retired-instruction and memory-stall counters for the main controller.
// Only built when MAIN_CTRL_PERF_CNT_EN is defined.
`ifdef MAIN_CTRL_PERF_CNT_EN
module main_ctrl_perf_counters
    import multicycle_main_controller_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  state_t               state,
    input  logic                 mem_ready,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 retire;
    logic                 stall;

    // Retire when a terminal state is about to fall back to FETCH; MEMWR only leaves on mem_ready
    always_comb begin
        retire      = is_terminal(state) && ((state != MEMWR) || mem_ready);
        stall       = is_mem_wait(state) && !mem_ready;
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (retire) begin
            instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
        end
        if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers, wrapping naturally at 2^CNT_WIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`endif

// File: rtl/multicycle_main_controller.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback, drives datapath enables/selects and ALUOp to the ALU decoder,
// and stalls on mem_ready. Defining MAIN_CTRL_PERF_CNT_EN adds the
// instr_cnt/stall_cnt ports and the performance counters behind them.
module multicycle_main_controller
    import multicycle_main_controller_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Op,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic                 illegal_op,
    output logic [3:0]           state_dbg
`ifdef MAIN_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;

    // Next-state logic; Op is only looked at in DECODE and MEMADR
    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET: state_d = FETCH;
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // State and sticky illegal-opcode flag; reset forces S_RESET so all strobes drop at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the control word; FETCH write enables are gated by mem_ready
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign PCEn       = ctrl.pc_write | (ctrl.branch & Zero);
    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;

`ifdef MAIN_CTRL_PERF_CNT_EN
    main_ctrl_perf_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_counters (
        .clk       (clk),
        .reset     (reset),
        .state     (state_q),
        .mem_ready (mem_ready),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: per-instruction expected state
// sequences built from the instruction-level latency rules, a per-state
// control table, and literal pins on key states.
module tb_multicycle_main_controller;

    localparam int S_RESET = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4,
                   MEMWB = 5, MEMWR = 6, EXECUTE = 7, ALUWB = 8, BRANCH = 9,
                   ADDIEX = 10, ADDIWB = 11, JUMP = 12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic        Zero;
    logic        mem_ready;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal_op;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic [3:0]  state_dbg;
    logic [31:0] instr_cnt, stall_cnt;
    logic [13:0] act_ctrl;

    int          compared = 0;
    int          mismatched = 0;
    bit          chk_en = 1'b0;
    int          exp_state = S_RESET;
    bit          exp_illegal = 1'b0;
    int unsigned exp_instr = 0;
    int unsigned exp_stall = 0;

    multicycle_main_controller #(.CNT_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
`ifdef MAIN_CTRL_PERF_CNT_EN
        ,
        .instr_cnt  (instr_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

`ifndef MAIN_CTRL_PERF_CNT_EN
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

    assign act_ctrl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Required control word for a state, written from the per-state output list
    function automatic logic [13:0] model_ctrl(input int st, input logic mr, input logic z);
        logic iord, mw, irw, rdst, m2r, rw, srca, pcen;
        logic [1:0] srcb, aop, pcs;
        {iord, mw, irw, rdst, m2r, rw, srca, pcen} = '0;
        {srcb, aop, pcs} = '0;
        case (st)
            FETCH:   begin srcb = 2'b01; irw = mr; pcen = mr; end
            DECODE:  srcb = 2'b11;
            MEMADR:  begin srca = 1'b1; srcb = 2'b10; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
            MEMWR:   begin iord = 1'b1; mw = 1'b1; end
            EXECUTE: begin srca = 1'b1; aop = 2'b10; end
            ALUWB:   begin rdst = 1'b1; rw = 1'b1; end
            BRANCH:  begin srca = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            ADDIEX:  begin srca = 1'b1; srcb = 2'b10; end
            ADDIWB:  rw = 1'b1;
            JUMP:    begin pcs = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {iord, mw, irw, rdst, m2r, rw, srca, srcb, aop, pcs, pcen};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, ADDI, JMP};
    endfunction

    // Every enabled cycle: compare all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state_dbg), exp_state);
            check("ctrl", 32'(act_ctrl), 32'(model_ctrl(exp_state, mem_ready, Zero)));
            check("illegal", 32'(illegal_op), 32'(exp_illegal));
`ifdef MAIN_CTRL_PERF_CNT_EN
            check("instr_cnt", instr_cnt, exp_instr);
            check("stall_cnt", stall_cnt, exp_stall);
`endif
        end
    end

    // Hand-written literal expectations for characteristic states
    task automatic pin_literals(input int st, input logic z);
        case (st)
            EXECUTE: begin
                check("exec_aluop", 32'(ALUOp), 32'h2);
                check("exec_srca", 32'(ALUSrcA), 32'h1);
                check("exec_srcb", 32'(ALUSrcB), 32'h0);
            end
            ALUWB: begin
                check("aluwb_regwrite", 32'(RegWrite), 32'h1);
                check("aluwb_regdst", 32'(RegDst), 32'h1);
            end
            MEMRD: begin
                check("memrd_iord", 32'(IorD), 32'h1);
                check("memrd_regwrite", 32'(RegWrite), 32'h0);
            end
            MEMWB:   check("memwb_memtoreg", 32'(MemtoReg), 32'h1);
            MEMWR:   check("memwr_memwrite", 32'(MemWrite), 32'h1);
            BRANCH: begin
                check("beq_aluop", 32'(ALUOp), 32'h1);
                check("beq_pcsrc", 32'(PCSrc), 32'h1);
                check("beq_pcen", 32'(PCEn), 32'(z));
            end
            default: ;
        endcase
    endtask

    // One instruction starting in FETCH: fw fetch waits, mw memory waits.
    // cut > 0 stops after that many cycles (used to land in a mid-instruction state).
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int lit_cycles, input int cut);
        int seq[$];
        bit rdy[$];
        int n;
        for (int k = 0; k < fw; k++) begin seq.push_back(FETCH); rdy.push_back(1'b0); end
        seq.push_back(FETCH);  rdy.push_back(1'b1);
        seq.push_back(DECODE); rdy.push_back(1'b0);
        case (op)
            LW: begin
                seq.push_back(MEMADR); rdy.push_back(1'b0);
                for (int k = 0; k < mw; k++) begin seq.push_back(MEMRD); rdy.push_back(1'b0); end
                seq.push_back(MEMRD);  rdy.push_back(1'b1);
                seq.push_back(MEMWB);  rdy.push_back(1'b0);
            end
            SW: begin
                seq.push_back(MEMADR); rdy.push_back(1'b0);
                for (int k = 0; k < mw; k++) begin seq.push_back(MEMWR); rdy.push_back(1'b0); end
                seq.push_back(MEMWR);  rdy.push_back(1'b1);
            end
            RT:   begin seq.push_back(EXECUTE); rdy.push_back(1'b0); seq.push_back(ALUWB); rdy.push_back(1'b0); end
            BEQ:  begin seq.push_back(BRANCH); rdy.push_back(1'b0); end
            ADDI: begin seq.push_back(ADDIEX); rdy.push_back(1'b0); seq.push_back(ADDIWB); rdy.push_back(1'b0); end
            JMP:  begin seq.push_back(JUMP); rdy.push_back(1'b0); end
            default: ;
        endcase
        if (cut == 0) check("latency", seq.size(), lit_cycles);
        n = (cut > 0) ? cut : seq.size();
        for (int i = 0; i < n; i++) begin
            #1;
            exp_state = seq[i];
            chk_en    = 1'b1;
            mem_ready = rdy[i];
            Zero      = z;
            Op        = (seq[i] == DECODE || seq[i] == MEMADR) ? op : ~op;
            #2;
            pin_literals(seq[i], z);
            @(posedge clk);
            if (seq[i] == DECODE && !is_legal(op)) exp_illegal = 1'b1;
            if (seq[i] inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP} || (seq[i] == MEMWR && rdy[i]))
                exp_instr++;
            if (seq[i] inside {FETCH, MEMRD, MEMWR} && !rdy[i]) exp_stall++;
        end
    endtask

    initial begin
        reset = 1'b1; Op = '0; Zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'h0);
        check("rst_ctrl", 32'(act_ctrl), 32'h0);
        check("rst_illegal", 32'(illegal_op), 32'h0);
        mem_ready = 1'b1;
        #1;
        check("rst_ctrl_mr", 32'(act_ctrl), 32'h0);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("released_no_edge", 32'(state_dbg), 32'h0);
        @(posedge clk);
        #1;
        check("first_edge_fetch", 32'(state_dbg), 32'h1);

        run_instr(RT,   1'b1, 0, 0, 4, 0);
        run_instr(LW,   1'b0, 0, 2, 7, 0);
        run_instr(BEQ,  1'b1, 0, 0, 3, 0);
        run_instr(BEQ,  1'b0, 1, 0, 4, 0);
        run_instr(SW,   1'b0, 1, 2, 7, 0);
        run_instr(ADDI, 1'b0, 0, 0, 4, 0);
        run_instr(JMP,  1'b1, 2, 0, 5, 0);

        // Unsupported opcode, then >20 cycles of normal traffic with the flag held
        run_instr(6'b111111, 1'b0, 0, 0, 2, 0);
        run_instr(RT,   1'b0, 0, 0, 4, 0);
        run_instr(LW,   1'b1, 0, 0, 5, 0);
        run_instr(SW,   1'b0, 0, 0, 4, 0);
        run_instr(ADDI, 1'b1, 0, 0, 4, 0);
        run_instr(JMP,  1'b0, 0, 0, 3, 0);
        run_instr(BEQ,  1'b1, 0, 0, 3, 0);
        check("illegal_sticky", 32'(illegal_op), 32'h1);

        // Reset in the middle of a waiting store
        run_instr(SW, 1'b0, 0, 3, 0, 3);
        #1;
        chk_en = 1'b0;
        mem_ready = 1'b0;
        Op = SW;
        #1;
        check("memwr_before_rst", 32'(MemWrite), 32'h1);
        check("memwr_state", 32'(state_dbg), 32'h6);
        reset = 1'b1;
        #1;
        check("rst_drops_memwrite", 32'(MemWrite), 32'h0);
        check("rst_async_state", 32'(state_dbg), 32'h0);
        check("rst_async_ctrl", 32'(act_ctrl), 32'h0);
        check("rst_clears_illegal", 32'(illegal_op), 32'h0);
        exp_illegal = 1'b0;
        exp_instr = 0;
        exp_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("held_in_reset", 32'(state_dbg), 32'h0);
        @(posedge clk);
        #1;
        check("release_fetch", 32'(state_dbg), 32'h1);

        // addi, j, sw with four stall cycles in total
        run_instr(ADDI, 1'b0, 1, 0, 5, 0);
        run_instr(JMP,  1'b0, 1, 0, 4, 0);
        run_instr(SW,   1'b1, 0, 2, 6, 0);
`ifdef MAIN_CTRL_PERF_CNT_EN
        #1;
        check("instr_cnt_lit", instr_cnt, 32'd3);
        check("stall_cnt_lit", stall_cnt, 32'd4);
`endif
        run_instr(RT, 1'b1, 0, 0, 4, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Multicycle MIPS main control FSM; sits directly upstream of the ALU decoder.
- Decodes Op[5:0] from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives ALUOp[1:0] (00 add, 01 sub, 10 use Funct) into the ALU decoder, plus all datapath enables and mux selects.
- Stalls on a memory ready handshake.

Parameters:
- CNT_WIDTH, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Op  input  6  opcode field of the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  register file destination: 0 = rt, 1 = rd.
- MemtoReg  output  1  writeback source: 0 = ALUOut, 1 = Data.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B operand: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  output  2  to ALU decoder.
- PCSrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  output  1  PC load enable.
- illegal_op  output  1  sticky flag: unsupported opcode decoded.
- state_dbg  output  4  current state encoding.
- instr_cnt  output  CNT_WIDTH  retired instructions (PERF_CNT_EN only).
- stall_cnt  output  CNT_WIDTH  mem_ready wait cycles (PERF_CNT_EN only).

Behaviour:
- Moore FSM; state register is clocked, outputs decode combinationally from state.
- Exceptions to Moore decode: PCWrite/IRWrite in FETCH are gated by mem_ready; PCEn = PCWrite | (Branch & Zero).
- Any output not listed for a state is 0.
- Reset (async, any time, including mid-instruction): state = S_RESET, all outputs 0, illegal_op = 0, counters = 0.
  - No stray write strobes while reset is asserted.
  - S_RESET -> FETCH on the first clock edge after reset is released.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 100011 (lw) / 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other Op -> FETCH and set illegal_op.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1; hold until mem_ready -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1, held high while waiting; on mem_ready -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Latency with mem_ready tied high:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
  - Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds 1 cycle.
- Op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- illegal_op clears only on reset.
- Unreachable state encodings -> FETCH.

Optional Feature:
- MAIN_CTRL_PERF_CNT_EN defined:
  - instr_cnt increments on each transition into FETCH from a terminal state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP).
  - stall_cnt increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Both counters wrap modulo 2^CNT_WIDTH.
- Undefined: counter ports are absent and no counter logic is built.

Decomposition:
- Shared include/package holds:
  - opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU decoder;
  - 4-bit state encodings (S_RESET=0, FETCH=1 … JUMP=12).
- One sub-module under the macro: main_ctrl_perf_counters (inputs: state, mem_ready; outputs: both counters).

Test Plan:
- Reset asserted mid-MEMWR (MemWrite=1) -> MemWrite drops to 0 same cycle with no clock edge; state_dbg=0; first edge after release gives FETCH.
- Op=000000, mem_ready=1 -> FETCH, DECODE, EXECUTE (ALUOp=10, ALUSrcA=1, ALUSrcB=00), ALUWB (RegWrite=1, RegDst=1), FETCH: 4 cycles.
- Op=100011, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with IorD=1 and RegWrite=0; then MEMWB with MemtoReg=1; total 7 cycles.
- Op=000100, Zero=1 -> BRANCH with ALUOp=01, PCSrc=01, PCEn=1; repeat with Zero=0 -> PCEn=0.
- Op=111111 -> DECODE then FETCH; illegal_op=1 stays high across the following 20 cycles until reset.
- With the macro defined: 3 instructions (addi, j, sw) plus 4 stall cycles -> instr_cnt=3, stall_cnt=4.
